// File: rtl/signed_sat_add_arbiter.sv
// signed_sat_add_arbiter: round-robin shared W-bit signed saturating adder with a one-deep result stage
module signed_sat_add_arbiter #(
  parameter int W     = 4,
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_sum,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic                     res_sat,
  output logic [CNT_W-1:0]         sat_cnt
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, gnt, id_q, id_d;
  logic [W-1:0]      sum_q, sum_d, op_a, op_b, sum_c;
  logic [W:0]        sum_w;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d, found, can_accept, xfer, sat_c;
  // Round-robin search: walk downward from the farthest slot so the nearest valid requester wins last.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        gnt   = IW'((int'(ptr_q) + k) % N_REQ);
      end
  end
  // Saturating add on the granted operands; overflow shows as disagreement of the two top sum bits.
  always_comb begin
    op_a  = req_a[int'(gnt)*W +: W];
    op_b  = req_b[int'(gnt)*W +: W];
    sum_w = {op_a[W-1], op_a} + {op_b[W-1], op_b};
    sat_c = sum_w[W] ^ sum_w[W-1];
    sum_c = sat_c ? (sum_w[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sum_w[W-1:0];
  end
  // Output-stage FSM next state, handshake and register loads; a full stage refills in the cycle it drains.
  always_comb begin
    can_accept = (state_q == EMPTY) | res_ready;
    xfer       = found & can_accept;
    req_ready  = xfer ? N_REQ'(1) << gnt : '0;
    state_d    = xfer ? FULL : (res_ready ? EMPTY : state_q);
    ptr_d      = xfer ? ((int'(gnt) == N_REQ - 1) ? '0 : gnt + 1'b1) : ptr_q;
    sum_d      = xfer ? sum_c : sum_q;
    id_d       = xfer ? gnt : id_q;
    sat_d      = xfer ? sat_c : sat_q;
    cnt_d      = (xfer & sat_c & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  // State and result registers; reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end
  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;
  assign res_sat   = sat_q;
  assign sat_cnt   = cnt_q;
endmodule
